i2c_simple_target: RTL and testbench

Receiving end of the in-house two-wire byte link driven by the I2C simple master. It oversamples SCL/SDA on the system clock, detects START/STOP, and shifts in bytes LSB first with no address phase. It ACKs each byte by pulling SDA low during the 9th clock. It buffers up to MAX_BYTES bytes and publishes them atomically on STOP, to feed the 7-segment decoder side of the board link.

---
 rtl/i2c_simple_target_pkg.sv | 22 ++
 rtl/i2c_simple_target_if.sv | 32 +++
 rtl/i2c_simple_target_line_sync.sv | 40 ++++
 rtl/i2c_simple_target.sv | 194 +++++++++++++++++++
 tb/tb_i2c_simple_target.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_simple_target_pkg.sv
// rtl/i2c_simple_target_pkg.sv - shared types and constants for the two-wire byte target
//
// Contents:
//   MAX_BYTES_DEFAULT  default receive buffer depth
//   I2C_ACK            level the target drives on SDA to acknowledge a byte
//   i2c_tgt_state_t    receive FSM states
package i2c_pkg;

  localparam int MAX_BYTES_DEFAULT = 8;

  // Open-drain: the target only ever drives low, the pull-up provides high.
  localparam logic I2C_ACK = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RX_BITS  = 3'd1,
    ACK_WAIT = 3'd2,
    ACK      = 3'd3,
    COMMIT   = 3'd4
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_simple_target_if.sv
// rtl/i2c_simple_target_if.sv - two-wire line bundle between bus master and target
//
// Signals:
//   scl_in      SCL line as seen by the target (asynchronous)
//   sda_in      resolved wired-AND SDA line (asynchronous)
//   sda_out     level driven when sda_out_en is set (always low)
//   sda_out_en  1 = target pulls SDA low
// Modports:
//   master  drives the lines, observes the target's open-drain drive
//   slave   the target side
interface i2c_simple_target_if;

  logic scl_in;
  logic sda_in;
  logic sda_out;
  logic sda_out_en;

  modport master (
    output scl_in,
    output sda_in,
    input  sda_out,
    input  sda_out_en
  );

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_out,
    output sda_out_en
  );

endinterface

// File: rtl/i2c_simple_target_line_sync.sv
// rtl/i2c_simple_target_line_sync.sv - synchronizer plus edge detector for one bus line
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   din    asynchronous line input
//   level  synchronized line level
//   rise   level went 0 -> 1 since the previous sample
//   fall   level went 1 -> 0 since the previous sample
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Lines idle high on a two-wire bus; resetting to 1 keeps the edge
  // detectors from reporting a spurious falling edge out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_simple_target.sv
// rtl/i2c_simple_target.sv - two-wire byte receiver with ACK and atomic frame commit
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   bus          line bundle (slave modport): scl_in, sda_in, sda_out, sda_out_en
//   data_array   bytes of the last committed frame (unwritten entries 0)
//   rx_count     number of complete bytes in the last committed frame
//   frame_valid  one-cycle pulse when a frame is committed
//   busy         frame in progress (START seen, commit not yet done)
//   overflow     last committed frame carried more than MAX_BYTES bytes
//   bit_error    last committed frame ended with STOP in the middle of a byte
module i2c_simple_target
  import i2c_pkg::*;
#(
  parameter int MAX_BYTES   = MAX_BYTES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  i2c_simple_target_if.slave             bus,
  output logic [7:0]                     data_array [0:MAX_BYTES-1],
  output logic [$clog2(MAX_BYTES+1)-1:0] rx_count,
  output logic                           frame_valid,
  output logic                           busy,
  output logic                           overflow,
  output logic                           bit_error
);

  localparam int CNT_W = $clog2(MAX_BYTES+1);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_tgt_state_t state_q, state_d;

  logic [7:0]       shift_q;
  logic [3:0]       bit_cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [7:0]       shadow_q [0:MAX_BYTES-1];
  logic             ack_drive_q;
  logic             ovf_acc_q;
  logic             berr_acc_q;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.scl_in),
    .level (scl_lvl),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (bus.sda_in),
    .level (sda_lvl),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL must have been high in both the current and the previous sample;
  // an SDA edge coinciding with an SCL edge is ordinary data movement.
  assign start_det = scl_lvl & ~scl_rise & sda_fall;
  assign stop_det  = scl_lvl & ~scl_rise & sda_rise;

  assign bus.sda_out = I2C_ACK;
  assign busy        = (state_q != IDLE) || start_det;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_det) state_d = RX_BITS;
      end
      RX_BITS: begin
        if (start_det)                         state_d = RX_BITS;
        else if (stop_det)                     state_d = COMMIT;
        else if (scl_rise && bit_cnt_q == 4'd7) state_d = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (start_det)     state_d = RX_BITS;
        else if (stop_det) state_d = COMMIT;
        else if (scl_fall) state_d = ACK;
      end
      ACK: begin
        if (start_det)     state_d = RX_BITS;
        else if (stop_det) state_d = COMMIT;
        else if (scl_fall) state_d = RX_BITS;
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      idx_q          <= '0;
      ack_drive_q    <= 1'b0;
      ovf_acc_q      <= 1'b0;
      berr_acc_q     <= 1'b0;
      bus.sda_out_en <= 1'b0;
      rx_count       <= '0;
      frame_valid    <= 1'b0;
      overflow       <= 1'b0;
      bit_error      <= 1'b0;
      for (int i = 0; i < MAX_BYTES; i++) begin
        shadow_q[i]   <= '0;
        data_array[i] <= '0;
      end
    end else begin
      frame_valid <= 1'b0;
      // Driven from the registered state so the pull-down follows the
      // state change by one cycle in both directions.
      bus.sda_out_en <= (state_q == ACK) && ack_drive_q;

      if (start_det && state_q != COMMIT) begin
        // Fresh frame or repeated START: drop everything gathered so far,
        // the committed outputs stay as they are.
        bit_cnt_q   <= '0;
        idx_q       <= '0;
        ack_drive_q <= 1'b0;
        ovf_acc_q   <= 1'b0;
        berr_acc_q  <= 1'b0;
        for (int i = 0; i < MAX_BYTES; i++) begin
          shadow_q[i] <= '0;
        end
      end else begin
        case (state_q)
          RX_BITS: begin
            if (stop_det) begin
              // A STOP is always preceded by an SCL rise that shifted a
              // dummy bit, so one counted bit is a clean byte boundary.
              if (bit_cnt_q > 4'd1) berr_acc_q <= 1'b1;
            end else if (scl_rise) begin
              shift_q   <= {sda_lvl, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
          ACK_WAIT: begin
            if (stop_det) begin
              berr_acc_q <= 1'b1;
            end else if (scl_fall) begin
              if (idx_q < CNT_W'(MAX_BYTES)) begin
                for (int i = 0; i < MAX_BYTES; i++) begin
                  if (idx_q == CNT_W'(i)) shadow_q[i] <= shift_q;
                end
                idx_q       <= idx_q + CNT_W'(1);
                ack_drive_q <= 1'b1;
              end else begin
                ovf_acc_q   <= 1'b1;
                ack_drive_q <= 1'b0;
              end
            end
          end
          ACK: begin
            if (!stop_det && scl_fall) begin
              bit_cnt_q   <= '0;
              ack_drive_q <= 1'b0;
            end
          end
          COMMIT: begin
            for (int i = 0; i < MAX_BYTES; i++) begin
              data_array[i] <= shadow_q[i];
            end
            rx_count    <= idx_q;
            overflow    <= ovf_acc_q;
            bit_error   <= berr_acc_q;
            frame_valid <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_simple_target.sv
// tb/tb_i2c_simple_target.sv - self-checking bench for i2c_simple_target
module tb_i2c_simple_target;
  localparam int MAXB = 8;
  localparam int SYNC = 2;
  localparam int H    = 12;

  typedef struct {
    int              nbytes;
    logic [9:0][7:0] bytes;
    int              nextra;
    logic [7:0]      extra;
    logic [3:0]      exp_cnt;
    logic            exp_ovf;
    logic            exp_berr;
  } vec_t;

  typedef struct {
    logic [3:0]      cnt;
    logic [7:0][7:0] data;
    logic            ovf;
    logic            berr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_scl, drv_sda;
  logic [7:0] data_array [0:MAXB-1];
  logic [3:0] rx_count;
  logic       frame_valid, busy, overflow, bit_error;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_stop_cyc = 0;
  int   ncommit = 0;
  int   nexp = 0;
  logic fv_prev = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[5];

  i2c_simple_target_if bus();

  assign bus.scl_in = drv_scl;
  assign bus.sda_in = drv_sda & ~bus.sda_out_en;

  i2c_simple_target #(.MAX_BYTES(MAXB), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .data_array  (data_array),
    .rx_count    (rx_count),
    .frame_valid (frame_valid),
    .busy        (busy),
    .overflow    (overflow),
    .bit_error   (bit_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sda_out_en"}, int'(bus.sda_out_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_rx_count"}, int'(rx_count), 0);
    chk({tag, "_frame_valid"}, int'(frame_valid), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
    chk({tag, "_bit_error"}, int'(bit_error), 0);
    for (int k = 0; k < MAXB; k++)
      chk($sformatf("%s_data[%0d]", tag, k), int'(data_array[k]), 0);
  endtask

  task automatic bus_start();
    drv_sda = 1'b0;
    wclk(H);
    drv_scl = 1'b0;
    wclk(2);
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic send_bit(input logic b);
    wclk(2);
    drv_sda = b;
    wclk(H - 2);
    drv_scl = 1'b1;
    wclk(H);
    drv_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack);
    int   got;
    logic ackd;
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    got = 0;
    for (int n = 1; n <= H; n++) begin
      wclk(1);
      if (n == 1) drv_sda = 1'b1;
      if (bus.sda_out_en && got == 0) got = n;
    end
    drv_scl = 1'b1;
    wclk(H / 2);
    ackd = ~bus.sda_in;
    wclk(H - H / 2);
    drv_scl = 1'b0;
    chk($sformatf("ack_%02h", b), int'(ackd), int'(exp_ack));
    chk($sformatf("ack_latency_%02h", b), got, exp_ack ? SYNC + 2 : 0);
  endtask

  task automatic bus_stop();
    wclk(2);
    drv_sda = 1'b0;
    wclk(H - 2);
    drv_scl = 1'b1;
    wclk(H);
    drv_sda = 1'b1;
    last_stop_cyc = cyc;
    wclk(H);
  endtask

  task automatic bus_rstart();
    wclk(2);
    drv_sda = 1'b1;
    wclk(H - 2);
    drv_scl = 1'b1;
    wclk(H);
    drv_sda = 1'b0;
    wclk(H);
    drv_scl = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] cnt, input logic [7:0][7:0] data,
                          input logic ovf, input logic berr);
    exp_t e;
    e.cnt  = cnt;
    e.data = data;
    e.ovf  = ovf;
    e.berr = berr;
    exp_q.push_back(e);
    nexp++;
  endtask

  // Commit monitor: pops one expected frame per frame_valid pulse.
  always @(negedge clk) begin
    if (!rst && frame_valid) begin
      chk("fv_width", int'(fv_prev), 0);
      if (!fv_prev) begin
        ncommit++;
        chk("busy_at_commit", int'(busy), 0);
        chk("fv_latency", cyc - last_stop_cyc, SYNC + 2);
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rx_count", int'(rx_count), int'(mon_e.cnt));
          chk("overflow", int'(overflow), int'(mon_e.ovf));
          chk("bit_error", int'(bit_error), int'(mon_e.berr));
          for (int k = 0; k < MAXB; k++)
            chk($sformatf("data[%0d]", k), int'(data_array[k]), int'(mon_e.data[k]));
        end
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    logic [7:0][7:0] ed;

    for (int v = 0; v < 5; v++) begin
      vecs[v].bytes  = '0;
      vecs[v].nextra = 0;
      vecs[v].extra  = '0;
      vecs[v].exp_ovf  = 1'b0;
      vecs[v].exp_berr = 1'b0;
    end
    vecs[0].nbytes = 3;
    vecs[0].bytes[0] = 8'hA5; vecs[0].bytes[1] = 8'h3C; vecs[0].bytes[2] = 8'hFF;
    vecs[0].exp_cnt = 4'd3;
    vecs[1].nbytes = 8;
    for (int k = 0; k < 8; k++) vecs[1].bytes[k] = 8'(k + 1);
    vecs[1].exp_cnt = 4'd8;
    vecs[2].nbytes = 9;
    for (int k = 0; k < 9; k++) vecs[2].bytes[k] = 8'(k + 8'h11);
    vecs[2].exp_cnt = 4'd8;
    vecs[2].exp_ovf = 1'b1;
    vecs[3].nbytes = 1;
    vecs[3].bytes[0] = 8'h5A;
    vecs[3].nextra = 4;
    vecs[3].extra  = 8'b0000_1011;
    vecs[3].exp_cnt = 4'd1;
    vecs[3].exp_berr = 1'b1;
    vecs[4].nbytes = 0;
    vecs[4].exp_cnt = 4'd0;

    rst = 1'b1;
    drv_scl = 1'b1;
    drv_sda = 1'b1;
    wclk(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wclk(H);

    for (int v = 0; v < 5; v++) begin
      bus_start();
      for (int i = 0; i < vecs[v].nbytes; i++)
        send_byte(vecs[v].bytes[i], i < MAXB);
      for (int j = 0; j < vecs[v].nextra; j++)
        send_bit(vecs[v].extra[j]);
      for (int k = 0; k < MAXB; k++)
        ed[k] = (k < vecs[v].nbytes) ? vecs[v].bytes[k] : 8'h00;
      push_exp(vecs[v].exp_cnt, ed, vecs[v].exp_ovf, vecs[v].exp_berr);
      bus_stop();
      wclk(H);
    end

    // Repeated START discards the first two bytes without a commit.
    bus_start();
    send_byte(8'h77, 1'b1);
    send_byte(8'h88, 1'b1);
    bus_rstart();
    send_byte(8'hC3, 1'b1);
    ed = '0;
    ed[0] = 8'hC3;
    push_exp(4'd1, ed, 1'b0, 1'b0);
    bus_stop();
    wclk(H);

    // Reset while the target is pulling SDA low for an ACK.
    bus_start();
    for (int i = 0; i < 8; i++) send_bit(1'(8'h96 >> i));
    for (int n = 0; n < 20 && !bus.sda_out_en; n++) wclk(1);
    chk("ack_before_rst", int'(bus.sda_out_en), 1);
    rst = 1'b1;
    wclk(1);
    check_reset_outputs("midrst");
    rst = 1'b0;
    drv_sda = 1'b1;
    wclk(H);
    drv_scl = 1'b1;
    wclk(H);

    bus_start();
    send_byte(8'h3A, 1'b1);
    ed = '0;
    ed[0] = 8'h3A;
    push_exp(4'd1, ed, 1'b0, 1'b0);
    bus_stop();
    wclk(4 * H);

    chk("commit_count", ncommit, nexp);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
